// File: rtl/cache_refill_ctrl.sv
// Miss/refill and write-through controller sitting between the CPU, a direct-mapped cache and main memory.
// Handles read hits combinationally, read refills and write-through stores, and a sticky memory timeout error.
module cache_refill_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wrdata,
    output logic             stall,
    output logic [31:0]      cpu_rdata,
    output logic [31:0]      cache_addr,
    input  logic             cache_hit,
    input  logic [31:0]      cache_q,
    output logic             cache_wren,
    output logic [31:0]      cache_wrdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wrdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             err
);

    localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_RD,
        S_FILL,
        S_MEM_WR,
        S_WR_UPD,
        S_ERR
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     a_reg, a_next;
    logic [31:0]     d_reg, d_next;
    logic [WC_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic            hit_inc, miss_inc;
    logic [1:0]      cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            a_reg        <= '0;
            d_reg        <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            a_reg        <= a_next;
            d_reg        <= d_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        a_next        = a_reg;
        d_next        = d_reg;
        wait_cnt_next = wait_cnt_reg;
        stall         = 1'b0;
        cpu_rdata     = '0;
        cache_addr    = a_reg;
        cache_wren    = 1'b0;
        cache_wrdata  = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wrdata    = '0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cache_addr = cpu_addr;
                if (cpu_wr) begin
                    stall         = 1'b1;
                    a_next        = cpu_addr;
                    d_next        = cpu_wrdata;
                    wait_cnt_next = '0;
                    state_next    = S_MEM_WR;
                end else if (cpu_rd) begin
                    if (cache_hit) begin
                        cpu_rdata = cache_q;
                        hit_inc   = 1'b1;
                    end else begin
                        stall         = 1'b1;
                        a_next        = cpu_addr;
                        miss_inc      = 1'b1;
                        wait_cnt_next = '0;
                        state_next    = S_MEM_RD;
                    end
                end
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = a_reg;
                stall    = 1'b1;
                // An ack arriving on the last allowed cycle still completes normally.
                if (mem_ack) begin
                    d_next     = mem_rdata;
                    state_next = S_FILL;
                end else if (wait_cnt_reg == WC_W'(TIMEOUT - 1)) begin
                    state_next = S_ERR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WC_W'(1);
                end
            end
            S_FILL: begin
                cache_wren   = 1'b1;
                cache_wrdata = d_reg;
                cpu_rdata    = d_reg;
                state_next   = S_IDLE;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = a_reg;
                mem_wrdata = d_reg;
                stall      = 1'b1;
                if (mem_ack) begin
                    state_next = S_WR_UPD;
                end else if (wait_cnt_reg == WC_W'(TIMEOUT - 1)) begin
                    state_next = S_ERR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WC_W'(1);
                end
            end
            S_WR_UPD: begin
                cache_wren   = 1'b1;
                cache_wrdata = d_reg;
                state_next   = S_IDLE;
            end
            S_ERR: begin
                stall = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Reset dominates the handshake outputs so nothing leaks out mid-transaction.
        if (rst) begin
            stall      = 1'b1;
            mem_req    = 1'b0;
            cache_wren = 1'b0;
        end
    end

    assign cnt_inc = {miss_inc, hit_inc};
    assign err     = (state_reg == S_ERR);

    // Index 0 counts read hits, index 1 counts read misses; both stick at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] count_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    count_reg <= '0;
                end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign hit_cnt  = g_cnt[0].count_reg;
    assign miss_cnt = g_cnt[1].count_reg;

endmodule
